// File: rtl/tag_run_ctrl.sv
// rtl/tag_run_ctrl.sv - tagger run sequencer with show-ahead readout FIFO and drop accounting
module tag_run_ctrl #(
    parameter int AW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] run_len,
    input  logic [31:0]   tag_data,
    input  logic          tag_ready,
    output logic          tagger_clear,
    output logic          tagger_operate,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          busy,
    output logic          overflow,
    output logic [CW-1:0] drop_cnt,
    output logic [CW-1:0] frame_cnt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] run_len_q, run_len_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;
    logic          clear_q, clear_d;
    logic          operate_q, operate_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [DEPTH];

    logic [AW:0]   fill_cnt;
    logic          full;
    logic          accept;
    logic          wr_en;
    logic          drop;
    logic          pop;
    logic          last_marker;

    always_comb begin
        fill_cnt    = wr_ptr_q - rd_ptr_q;
        full        = (fill_cnt == (AW+1)'(DEPTH));
        accept      = tag_ready && (state_q == RUN);
        wr_en       = accept && !full;
        drop        = accept && full;
        pop         = out_valid_q && out_ack;
        // frame_cnt_q still holds the pre-edge count, so equality means marker run_len+1
        last_marker = accept && tag_data[31] && (run_len_q != '0) && (frame_cnt_q == run_len_q);
    end

    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);

        if (accept && tag_data[31] && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + CW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    run_len_d   = run_len;
                    overflow_d  = 1'b0;
                    drop_cnt_d  = '0;
                    frame_cnt_d = '0;
                    state_d     = ARM;
                end
            end
            ARM:   state_d = stop ? DRAIN : RUN;
            RUN: begin
                if (stop || last_marker) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_ptr_d == rd_ptr_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        clear_d   = (state_d != RUN);
        operate_d = (state_d == RUN);
        busy_d    = (state_d != IDLE);

        // The word written on this edge becomes visible one cycle later
        out_valid_d = (rd_ptr_d != wr_ptr_q);
        out_data_d  = out_valid_d ? mem_q[rd_ptr_d[AW-1:0]] : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_len_q   <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            clear_q     <= 1'b1;
            operate_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            clear_q     <= clear_d;
            operate_q   <= operate_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tag_data;
        end
    end

    assign tagger_clear   = clear_q;
    assign tagger_operate = operate_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign overflow       = overflow_q;
    assign drop_cnt       = drop_cnt_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: doc/tag_run_ctrl.md
Name: tag_run_ctrl

Overview:
- Run controller and readout buffer for the pulse-registration/time-stamping datapath.
- Sequences the tagger's clear/operate inputs through arm, run and stop phases, and counts rollover marker words to end a run after a programmed number of frames.
- Captures tag words into a FIFO and presents them to the host-side reader with a valid/ack handshake, with sticky overflow reporting.

Parameters:
- AW, 4, FIFO address width; depth = 2**AW words (16).
- CW, 16, width of the run-length, frame and drop counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE.
- stop  in  1  single-cycle abort request; honoured in ARM and RUN.
- run_len  in  CW  number of complete frames per run; 0 = continuous until stop. Sampled in IDLE on start.
- tag_data  in  32  tagger word: [31] rollover marker, [30:27] channel, [26:0] time.
- tag_ready  in  1  tag_data valid this cycle.
- tagger_clear  out  1  drives the tagger clear input.
- tagger_operate  out  1  drives the tagger operate input.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ack  in  1  reader accepts out_data this cycle.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: at least one word dropped this run.
- drop_cnt  out  CW  number of dropped words this run; saturates at all-ones.
- frame_cnt  out  CW  number of accepted marker words this run.

Behaviour:
- Reset values:
  - state = IDLE; tagger_clear = 1; tagger_operate = 0.
  - FIFO empty; out_valid = 0; out_data = 0.
  - busy = 0; overflow = 0; drop_cnt = 0; frame_cnt = 0.
- All outputs are registered. out_data is the registered FIFO head (show-ahead).
- State machine (2-bit encoding: IDLE=0, ARM=1, RUN=2, DRAIN=3):
  - IDLE: clear=1, operate=0. On start: latch run_len, zero overflow/drop_cnt/frame_cnt, go to ARM.
  - ARM: lasts one cycle; clear=1, operate=0. Next state is RUN, or DRAIN if stop is asserted.
  - RUN: clear=0, operate=1.
    - Exit to DRAIN on stop.
    - Exit to DRAIN on acceptance of marker number run_len+1 when run_len != 0.
    - Outputs change on the exit edge.
  - DRAIN: clear=1, operate=0. Go to IDLE on the cycle the FIFO becomes empty, i.e. count = 0 after the edge.
- Capture:
  - A word is accepted only when tag_ready=1 and state=RUN in that cycle. Words in other states are ignored and not counted as drops.
  - Marker word (tag_data[31]=1) increments frame_cnt; saturates at all-ones.
  - The terminating marker is written to the FIFO like any other word.
- FIFO:
  - Full is evaluated from the pre-edge count.
  - A write while full is dropped, even if a read occurs in the same cycle. A drop sets overflow and increments drop_cnt.
  - A read and a write in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - A word accepted at edge n gives out_valid=1 after edge n+1 when the FIFO was empty.
- Handshake:
  - A transfer occurs when out_valid and out_ack are both 1.
  - out_data is held stable while out_valid=1 and out_ack=0.
  - out_ack while out_valid=0 has no effect.
- Pointers are AW+1 bits; wrap-around at depth is transparent.
- Simultaneous events:
  - start and stop in IDLE: start wins and stop is ignored.
  - start outside IDLE is ignored.
  - stop in IDLE or DRAIN is ignored.
- Reset mid-run: asynchronous return to reset values; FIFO contents are discarded.

Test Plan:
- Reset, then start with run_len=2, markers every 8 cycles, no hits:
  - tagger_clear 1→1→0 over IDLE→ARM→RUN.
  - Exit to DRAIN on the 3rd marker; frame_cnt=3.
  - Reader receives exactly 3 words with bit31=1.
  - Returns to IDLE; busy=0.
- RUN with run_len=0, a hit word 0x0800_0005, out_ack held 0:
  - out_valid rises one cycle after acceptance; data holds at 0x0800_0005.
  - Ack pulse pops it; out_valid falls next cycle.
- Fill with 20 hit words while out_ack=0:
  - 16 words stored; overflow=1; drop_cnt=4.
  - Draining yields words 1..16 in order.
  - A subsequent start clears overflow and drop_cnt.
- FIFO full, tag_ready and out_ack in the same cycle:
  - The incoming word is dropped (drop_cnt+1); the head is popped; count=15.
- stop asserted in ARM, and separately stop mid-RUN with 5 words queued:
  - ARM case goes to DRAIN, then IDLE with an empty FIFO.
  - Mid-RUN case: tag_ready in DRAIN is ignored; all 5 words are read out before IDLE.
- rst_n pulsed low mid-RUN with 7 words queued:
  - Immediately: tagger_clear=1, operate=0, out_valid=0, frame_cnt=0.
  - After release, state is IDLE with an empty FIFO.
